// File: rtl/systolic_array.sv
// Weight-stationary ROWS x COLS fixed-point matrix-vector engine with internal input skew and output deskew.
// Latency: ROWS+COLS-1 cycles from activation vector to registered sum_out. No backpressure: one vector per cycle, never stalls.
module systolic_array #(
    parameter int SYSTOLIC_ARRAY_ROWS = 8,
    parameter int SYSTOLIC_ARRAY_COLS = 8,
    parameter int FIXED_POINT_WIDTH   = 16,
    parameter int FRAC_BITS           = 8
) (
    input  logic                                                  clk_in,
    input  logic                                                  rst_n_in,
    input  logic                                                  weights_valid_in,
    input  logic [SYSTOLIC_ARRAY_COLS-1:0][FIXED_POINT_WIDTH-1:0] weights_in,
    input  logic [SYSTOLIC_ARRAY_ROWS-1:0][FIXED_POINT_WIDTH-1:0] activations_in,
    output logic [SYSTOLIC_ARRAY_COLS-1:0][FIXED_POINT_WIDTH-1:0] sum_out
);
    localparam int ROWS = SYSTOLIC_ARRAY_ROWS;
    localparam int COLS = SYSTOLIC_ARRAY_COLS;
    localparam int W    = FIXED_POINT_WIDTH;

    logic [ROWS-1:0][COLS-1:0][W-1:0] w_q, w_d;
    logic [ROWS-1:0][COLS-2:0][W-1:0] a_q, a_d;
    logic [ROWS-1:0][COLS-1:0][W-1:0] p_q, p_d;
    logic [ROWS-1:0][COLS-1:0][W-1:0] a_in;
    logic [ROWS-1:0][W-1:0]           a_col0;
    logic [COLS-1:0][W-1:0]           bottom_dly;
    logic [COLS-1:0][W-1:0]           sum_q;

    // Full 2W-bit signed product, rescaled to the fixed-point format and truncated.
    function automatic logic [W-1:0] fx_mul(input logic [W-1:0] a, input logic [W-1:0] b);
        logic signed [2*W-1:0] ea;
        logic signed [2*W-1:0] eb;
        ea = {{W{a[W-1]}}, a};
        eb = {{W{b[W-1]}}, b};
        return W'((ea * eb) >>> FRAC_BITS);
    endfunction

    always_comb begin
        w_d  = w_q;
        a_d  = a_q;
        p_d  = p_q;
        a_in = '0;
        if (weights_valid_in) begin
            w_d[0] = weights_in;
            for (int r = 1; r < ROWS; r++) begin
                w_d[r] = w_q[r-1];
            end
        end
        for (int r = 0; r < ROWS; r++) begin
            a_in[r][0] = a_col0[r];
            for (int c = 1; c < COLS; c++) begin
                a_in[r][c] = a_q[r][c-1];
            end
            for (int c = 0; c < COLS-1; c++) begin
                a_d[r][c] = a_in[r][c];
            end
        end
        for (int c = 0; c < COLS; c++) begin
            p_d[0][c] = fx_mul(a_in[0][c], w_q[0][c]);
            for (int r = 1; r < ROWS; r++) begin
                p_d[r][c] = p_q[r-1][c] + fx_mul(a_in[r][c], w_q[r][c]);
            end
        end
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            w_q   <= '0;
            a_q   <= '0;
            p_q   <= '0;
            sum_q <= '0;
        end else begin
            w_q   <= w_d;
            a_q   <= a_d;
            p_q   <= p_d;
            sum_q <= bottom_dly;
        end
    end

    // Row r reaches column 0 r cycles late so its partial sum meets the one coming down.
    assign a_col0[0] = activations_in[0];
    for (genvar gr = 1; gr < ROWS; gr++) begin : g_skew
        logic [gr-1:0][W-1:0] sk_q;
        always_ff @(posedge clk_in or negedge rst_n_in) begin
            if (!rst_n_in) begin
                sk_q <= '0;
            end else begin
                sk_q[0] <= activations_in[gr];
                for (int k = 1; k < gr; k++) begin
                    sk_q[k] <= sk_q[k-1];
                end
            end
        end
        assign a_col0[gr] = sk_q[gr-1];
    end

    // Early columns wait for the last column so the whole result vector leaves together.
    for (genvar gc = 0; gc < COLS-1; gc++) begin : g_deskew
        localparam int D = COLS-1-gc;
        logic [D-1:0][W-1:0] dk_q;
        always_ff @(posedge clk_in or negedge rst_n_in) begin
            if (!rst_n_in) begin
                dk_q <= '0;
            end else begin
                dk_q[0] <= p_q[ROWS-1][gc];
                for (int k = 1; k < D; k++) begin
                    dk_q[k] <= dk_q[k-1];
                end
            end
        end
        assign bottom_dly[gc] = dk_q[D-1];
    end
    assign bottom_dly[COLS-1] = p_q[ROWS-1][COLS-1];

    assign sum_out = sum_q;
endmodule

// File: tb/tb_systolic_array.sv
// Scoreboard bench for systolic_array: stimulus pushes hand-computed result vectors tagged with
// their due cycle; a monitor pops and compares each one when that cycle's output is presented.
module tb_systolic_array;
    localparam int R   = 8;
    localparam int C   = 8;
    localparam int W   = 16;
    localparam int LAT = R + C - 1;

    logic                   clk_in = 1'b0;
    logic                   rst_n_in;
    logic                   weights_valid_in;
    logic [C-1:0][W-1:0]    weights_in;
    logic [R-1:0][W-1:0]    activations_in;
    logic [C-1:0][W-1:0]    sum_out;

    systolic_array #(
        .SYSTOLIC_ARRAY_ROWS(R),
        .SYSTOLIC_ARRAY_COLS(C),
        .FIXED_POINT_WIDTH  (W),
        .FRAC_BITS          (8)
    ) dut (
        .clk_in          (clk_in),
        .rst_n_in        (rst_n_in),
        .weights_valid_in(weights_valid_in),
        .weights_in      (weights_in),
        .activations_in  (activations_in),
        .sum_out         (sum_out)
    );

    always #5 clk_in = ~clk_in;

    typedef struct {
        int                  due;
        logic [C-1:0][W-1:0] exp;
        int                  tag;
    } exp_t;

    exp_t sbq[$];
    exp_t head;
    int   checks   = 0;
    int   failures = 0;
    int   cyc      = 0;

    // Monitor: output of edge n is sampled 1 time unit after that edge.
    always begin
        @(posedge clk_in);
        #1;
        cyc++;
        if (sbq.size() > 0 && sbq[0].due == cyc) begin
            head = sbq.pop_front();
            checks++;
            if (sum_out !== head.exp) begin
                failures++;
                $display("FAIL vec tag=%0d cyc=%0d got=%h want=%h", head.tag, cyc, sum_out, head.exp);
            end
        end
    end

    function automatic logic [C-1:0][W-1:0] fillc(input logic [W-1:0] v);
        logic [C-1:0][W-1:0] o;
        for (int c = 0; c < C; c++) o[c] = v;
        return o;
    endfunction

    function automatic logic [R-1:0][W-1:0] fillr(input logic [W-1:0] v);
        logic [R-1:0][W-1:0] o;
        for (int r = 0; r < R; r++) o[r] = v;
        return o;
    endfunction

    // Weight patterns: 0 identity, 1 all 1.0, 2 diag 0.5, 3 diag -1.0, 4 all 2.0
    function automatic logic [W-1:0] wval(input int kind, input int r, input int c);
        case (kind)
            0:       return (r == c) ? 16'h0100 : 16'h0000;
            1:       return 16'h0100;
            2:       return (r == c) ? 16'h0080 : 16'h0000;
            3:       return (r == c) ? 16'hFF00 : 16'h0000;
            default: return 16'h0200;
        endcase
    endfunction

    // Leaves weights_valid_in high after the last row; the next send drops it on the following edge.
    task automatic load(input int kind);
        for (int r = R - 1; r >= 0; r--) begin
            @(negedge clk_in);
            weights_valid_in = 1'b1;
            activations_in   = '0;
            for (int c = 0; c < C; c++) weights_in[c] = wval(kind, r, c);
        end
    endtask

    task automatic send(input logic [R-1:0][W-1:0] act, input logic [C-1:0][W-1:0] e, input int tag);
        exp_t x;
        @(negedge clk_in);
        weights_valid_in = 1'b0;
        weights_in       = '0;
        activations_in   = act;
        x.due = cyc + 1 + LAT;
        x.exp = e;
        x.tag = tag;
        sbq.push_back(x);
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk_in);
            weights_valid_in = 1'b0;
            activations_in   = '0;
        end
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (sbq.size() > 0 && n < 200) begin
            @(negedge clk_in);
            n++;
        end
        if (sbq.size() > 0) begin
            checks++;
            failures++;
            $display("FAIL drain_timeout pending=%0d required=0", sbq.size());
            sbq.delete();
        end
    endtask

    initial begin
        logic [R-1:0][W-1:0] act;
        logic [C-1:0][W-1:0] e;

        rst_n_in         = 1'b0;
        weights_valid_in = 1'b0;
        weights_in       = '0;
        activations_in   = '0;
        #12;
        checks++;
        if (sum_out !== '0) begin
            failures++;
            $display("FAIL reset_state got=%h want=0", sum_out);
        end
        @(negedge clk_in);
        rst_n_in = 1'b1;

        // Zero weights after reset: outputs stay zero.
        for (int k = 0; k < 3; k++) send(fillr(16'h0100), fillc(16'h0000), 1);
        idle(1);
        drain();

        // Identity: activation r*1.0 yields column c = c*1.0; first send lands right after the last load edge.
        load(0);
        for (int r = 0; r < R; r++) act[r] = 16'(r * 16'h0100);
        for (int c = 0; c < C; c++) e[c] = 16'(c * 16'h0100);
        send(act, e, 2);

        // Streaming, back-to-back, in order.
        for (int k = 1; k <= 10; k++) send(fillr(16'(k * 16'h0010)), fillc(16'(k * 16'h0010)), 3);
        idle(1);
        drain();

        // Asynchronous reset mid-stream: outputs are nonzero here and must clear without an edge.
        for (int k = 0; k < 20; k++) send(fillr(16'h0100), fillc(16'h0100), 4);
        #2;
        rst_n_in = 1'b0;
        #1;
        checks++;
        if (sum_out !== '0) begin
            failures++;
            $display("FAIL async_reset got=%h want=0", sum_out);
        end
        sbq.delete();
        @(negedge clk_in);
        rst_n_in = 1'b1;
        for (int k = 0; k < 5; k++) send(fillr(16'h0100), fillc(16'h0000), 5);
        idle(1);
        drain();

        // All ones: 8 * 1.0 * 1.0 = 8.0
        load(1);
        send(fillr(16'h0100), fillc(16'h0800), 6);
        idle(1);
        drain();

        // Fractional: 0.5 * 0.5 = 0.25 on the diagonal only
        load(2);
        send(fillr(16'h0080), fillc(16'h0040), 7);
        idle(1);
        drain();

        // Signed: -1.0 * 2.0 = -2.0, then unchanged after a long hold
        load(3);
        send(fillr(16'h0200), fillc(16'hFE00), 8);
        idle(1);
        drain();
        idle(100);
        send(fillr(16'h0200), fillc(16'hFE00), 9);
        send(fillr(16'h0100), fillc(16'hFF00), 9);
        idle(1);
        drain();

        // Reload all 2.0: 8 * 1.0 * 2.0 = 16.0
        load(4);
        send(fillr(16'h0100), fillc(16'h1000), 10);
        idle(1);
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog expired at cyc=%0d", cyc);
        $fatal(1);
    end
endmodule
